hub75_bcm_driver: RTL and testbench
===================================

Name: hub75_bcm_driver

Overview:
Parametrised HUB75 LED-matrix driver. It scans 2^ROW_ADDR_W row pairs, with upper and lower halves driven simultaneously. Colour depth is BPC bits per channel, using binary-coded modulation (BCM) over bit planes. Pixels are read from an external synchronous framebuffer RAM (1-cycle read latency). It sits between the framebuffer and the panel connector and generalises the fixed 1-bit-colour matrix driver.

Parameters:
COLS, 32, pixels per row shifted per plane; power of two, ≥2; COL_W = clog2(COLS)
ROW_ADDR_W, 4, width of mat_row; scan rows = 2^ROW_ADDR_W
BPC, 4, bits per colour channel (BCM planes), 1..8
DISP_BASE, 8, clk cycles of OE-on time for plane 0; plane p gets DISP_BASE<<p

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
enable  in  1  run request, sampled at frame boundary / in IDLE
fb_addr  out  ROW_ADDR_W+COL_W  {scan_row, col} read address
fb_data  in  6*BPC  {b1,g1,r1,b0,g0,r0}, each BPC wide; *0 = upper half, *1 = lower half; valid 1 cycle after fb_addr
mat_r  out  2  {r1,r0} selected plane bit
mat_g  out  2  {g1,g0}
mat_b  out  2  {b1,b0}
mat_row  out  ROW_ADDR_W  row address to panel
mat_clk  out  1  shift clock; panel samples on rising edge
mat_lat  out  1  latch pulse, active high
mat_oe  out  1  output enable, active low
busy  out  1  high when not IDLE
frame_done  out  1  1-cycle pulse at end of last row's last plane

Behaviour:
- All outputs registered. Reset (rst=0, async): state=IDLE, mat_r/g/b=0, mat_clk=0, mat_lat=0, mat_oe=1, mat_row=0, fb_addr=0, busy=0, frame_done=0, row=0, plane=0, col=0.
- States: IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: mat_oe=1. If enable=1: go to PREFETCH with row=0, plane=0.
- PREFETCH (1 cycle): fb_addr<={row,0}.
- SHIFT (2*COLS cycles), per column c:
  - phase0: mat_clk<=0; mat_{r,g,b}<=bit[plane] of the fb_data fields.
  - phase1: mat_clk<=1; fb_addr<={row,c+1}.
  - After phase1 of c=COLS-1, go to BLANK. fb_addr past the last column is don't-care; it must not wrap into the next row.
- BLANK (1 cycle): mat_clk<=0, mat_oe=1.
- LATCH (1 cycle): mat_lat<=1, mat_row<=row. mat_lat is high for exactly one cycle and mat_oe is high throughout.
- DISPLAY (DISP_BASE<<plane cycles): mat_oe<=0, mat_lat<=0. mat_oe is low for exactly that count.
- On DISPLAY exit:
  - If plane<BPC-1: plane++, go to PREFETCH.
  - Else plane=0 and row++ (wraps at 2^ROW_ADDR_W). On wrap, frame_done pulses in the first cycle after DISPLAY. If enable=0 then, go to IDLE; otherwise go to PREFETCH.
- enable deasserted mid-frame has no effect until the frame boundary. Frames are never truncated.
- mat_oe=1 in every state except DISPLAY, so no ghosting during shift or latch.
- Cycles per plane p = 2*COLS+3+(DISP_BASE<<p). Frame length = 2^ROW_ADDR_W × Σp.
- Reset asserted mid-operation: immediate return to reset values. mat_oe goes high asynchronously.
- Data plane bit order: plane 0 = LSB of each BPC field.

Test Plan:
- Reset/idle: hold rst=0, then release with enable=0 for 20 cycles -> mat_oe=1, busy=0, mat_lat=0, mat_clk=0 throughout.
- Shift data: COLS=4, BPC=2, ROW_ADDR_W=1, DISP_BASE=2; RAM model with r0 field = column index -> plane0 rising mat_clk samples mat_r[0]=0,1,0,1; plane1 samples 0,0,1,1; exactly 4 rising edges per plane.
- BCM timing (same params): mat_oe low runs of 2 then 4 cycles alternate; each latch pulse is 1 cycle, precedes its OE window by exactly 1 cycle, and has mat_oe=1 during it.
- Row scan/frame: frame_done period = 56 cycles. mat_row shows 0 at first two latches, 1 at next two, then wraps to 0. fb_addr row field matches.
- Enable drop: deassert enable mid-row-0 -> frame completes, frame_done pulses, state returns to IDLE (busy=0) with no further mat_clk edges.
- Async reset mid-DISPLAY: rst=0 while mat_oe=0 -> mat_oe=1 before next clk edge. After release with enable=1, restarts at row 0, plane 0.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// rtl/hub75_bcm_driver.sv - HUB75 LED-matrix driver with binary-coded modulation over colour bit planes
module hub75_bcm_driver #(
  parameter int COLS       = 32,
  parameter int ROW_ADDR_W = 4,
  parameter int BPC        = 4,
  parameter int DISP_BASE  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  output logic [ROW_ADDR_W+$clog2(COLS)-1:0]    fb_addr,
  input  logic [6*BPC-1:0]                      fb_data,
  output logic [1:0]                            mat_r,
  output logic [1:0]                            mat_g,
  output logic [1:0]                            mat_b,
  output logic [ROW_ADDR_W-1:0]                 mat_row,
  output logic                                  mat_clk,
  output logic                                  mat_lat,
  output logic                                  mat_oe,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int COL_W    = $clog2(COLS);
  localparam int PLANE_W  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DISP_MAX = DISP_BASE << (BPC - 1);
  localparam int DISP_W   = $clog2(DISP_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t state, state_nxt;

  logic [ROW_ADDR_W-1:0] row;
  logic [PLANE_W-1:0]    plane;
  logic [COL_W-1:0]      col;
  logic                  phase;
  logic [DISP_W-1:0]     disp_cnt;
  logic [DISP_W-1:0]     disp_len;

  logic plane_last, frame_end, disp_done, col_last;
  logic [ROW_ADDR_W-1:0] row_start;

  logic [BPC-1:0] r0_f, g0_f, b0_f, r1_f, g1_f, b1_f;

  logic [ROW_ADDR_W+COL_W-1:0] fb_addr_d;
  logic [1:0]                  mat_r_d, mat_g_d, mat_b_d;
  logic [ROW_ADDR_W-1:0]       mat_row_d;
  logic                        mat_clk_d, mat_lat_d, mat_oe_d, busy_d, frame_done_d;

  assign {b1_f, g1_f, r1_f, b0_f, g0_f, r0_f} = fb_data;

  assign disp_len   = DISP_W'(DISP_BASE) << plane;
  assign plane_last = (plane == PLANE_W'(BPC - 1));
  assign frame_end  = plane_last && (&row);
  assign disp_done  = (disp_cnt == '0);
  assign col_last   = phase && (col == COL_W'(COLS - 1));

  // Row whose pixels the next PREFETCH will address
  always_comb begin
    row_start = row;
    if (state == S_IDLE)
      row_start = '0;
    else if (state == S_DISPLAY && plane_last)
      row_start = row + 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode; enable only matters in IDLE or at the end of a frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (enable) state_nxt = S_PREFETCH;
      S_PREFETCH: state_nxt = S_SHIFT;
      S_SHIFT:    if (col_last) state_nxt = S_BLANK;
      S_BLANK:    state_nxt = S_LATCH;
      S_LATCH:    state_nxt = S_DISPLAY;
      S_DISPLAY: begin
        if (disp_done) begin
          if (frame_end && !enable)
            state_nxt = S_IDLE;
          else
            state_nxt = S_PREFETCH;
        end
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Scan counters: row, plane, column/phase and display countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row      <= '0;
      plane    <= '0;
      col      <= '0;
      phase    <= 1'b0;
      disp_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          row   <= '0;
          plane <= '0;
        end
        S_PREFETCH: begin
          col   <= '0;
          phase <= 1'b0;
        end
        S_SHIFT: begin
          phase <= ~phase;
          if (phase)
            col <= col + 1'b1;
        end
        S_LATCH: disp_cnt <= disp_len - 1'b1;
        S_DISPLAY: begin
          if (!disp_done) begin
            disp_cnt <= disp_cnt - 1'b1;
          end else if (plane_last) begin
            plane <= '0;
            row   <= row + 1'b1;
          end else begin
            plane <= plane + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: address leads data by one cycle, pixel bits settle a cycle before mat_clk rises
  always_comb begin
    fb_addr_d    = fb_addr;
    mat_r_d      = mat_r;
    mat_g_d      = mat_g;
    mat_b_d      = mat_b;
    mat_row_d    = mat_row;
    mat_clk_d    = (state == S_SHIFT) && phase;
    mat_lat_d    = (state_nxt == S_LATCH);
    mat_oe_d     = (state_nxt != S_DISPLAY);
    busy_d       = (state_nxt != S_IDLE);
    frame_done_d = (state == S_DISPLAY) && disp_done && frame_end;
    if (state_nxt == S_PREFETCH)
      fb_addr_d = {row_start, {COL_W{1'b0}}};
    else if (state == S_SHIFT && !phase)
      fb_addr_d = {row, col + 1'b1};
    if (state == S_SHIFT && !phase) begin
      mat_r_d = {r1_f[plane], r0_f[plane]};
      mat_g_d = {g1_f[plane], g0_f[plane]};
      mat_b_d = {b1_f[plane], b0_f[plane]};
    end
    if (state_nxt == S_LATCH)
      mat_row_d = row;
  end

  // Output registers; OE is forced off asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_addr    <= '0;
      mat_r      <= '0;
      mat_g      <= '0;
      mat_b      <= '0;
      mat_row    <= '0;
      mat_clk    <= 1'b0;
      mat_lat    <= 1'b0;
      mat_oe     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fb_addr    <= fb_addr_d;
      mat_r      <= mat_r_d;
      mat_g      <= mat_g_d;
      mat_b      <= mat_b_d;
      mat_row    <= mat_row_d;
      mat_clk    <= mat_clk_d;
      mat_lat    <= mat_lat_d;
      mat_oe     <= mat_oe_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb/tb_hub75_bcm_driver.sv - directed self-checking bench for hub75_bcm_driver
module tb_hub75_bcm_driver;

  localparam int COLS       = 4;
  localparam int ROW_ADDR_W = 1;
  localparam int BPC        = 2;
  localparam int DISP_BASE  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  fb_addr;
  logic [11:0] fb_data;
  logic [1:0]  mat_r, mat_g, mat_b;
  logic [0:0]  mat_row;
  logic        mat_clk, mat_lat, mat_oe, busy, frame_done;

  int total = 0;
  int bad   = 0;

  hub75_bcm_driver #(
    .COLS(COLS), .ROW_ADDR_W(ROW_ADDR_W), .BPC(BPC), .DISP_BASE(DISP_BASE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b),
    .mat_row(mat_row), .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe(mat_oe),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer word {b1,g1,r1,b0,g0,r0}: r0=col, g0=row, r1=~col, rest zero
  function automatic logic [11:0] ram_word(input logic [2:0] a);
    logic [1:0] c;
    c = a[1:0];
    return {2'b00, 2'b00, ~c, 2'b00, {1'b0, a[2]}, c};
  endfunction

  // Synchronous RAM model, one cycle read latency
  always_ff @(posedge clk) fb_data <= ram_word(fb_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int cyc, run, rises_seg, viol, found;
  int first_rise, first_lat, first_oe;
  int lat_width_bad, lat_oe_bad, lat_follow_bad;
  int busy_at_fd;
  logic prev_clk, prev_lat;
  int rise_vec[$], rise_addr[$], lat_rows[$], rises_per[$], oe_runs[$], fd_times[$];

  initial begin
    rst    = 1'b0;
    enable = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_oe", mat_oe, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lat", mat_lat, 0);
    chk("rst_clk", mat_clk, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_row", mat_row, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_rgb", {mat_b, mat_g, mat_r}, 0);

    // Idle with enable low stays quiet
    rst  = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (mat_oe !== 1'b1 || busy !== 1'b0 || mat_lat !== 1'b0 || mat_clk !== 1'b0) viol++;
    end
    chk("idle_quiet", viol, 0);

    // Run two full frames and record panel activity
    enable         = 1'b1;
    cyc            = -1;
    run            = 0;
    rises_seg      = 0;
    first_rise     = -1;
    first_lat      = -1;
    first_oe       = -1;
    lat_width_bad  = 0;
    lat_oe_bad     = 0;
    lat_follow_bad = 0;
    prev_clk       = mat_clk;
    prev_lat       = mat_lat;
    repeat (113) begin
      @(negedge clk);
      cyc++;
      if (cyc == 0) begin
        chk("start_busy", busy, 1);
        chk("start_addr", fb_addr, 0);
      end
      if (mat_clk && !prev_clk) begin
        rise_vec.push_back(int'({mat_b, mat_g, mat_r}));
        rise_addr.push_back(int'(fb_addr));
        rises_seg++;
        if (first_rise < 0) first_rise = cyc;
      end
      if (mat_lat) begin
        if (prev_lat) lat_width_bad++;
        if (!mat_oe) lat_oe_bad++;
        if (!prev_lat) begin
          lat_rows.push_back(int'(mat_row));
          rises_per.push_back(rises_seg);
          rises_seg = 0;
          if (first_lat < 0) first_lat = cyc;
        end
      end
      if (prev_lat && mat_oe) lat_follow_bad++;
      if (!mat_oe) begin
        run++;
        if (first_oe < 0) first_oe = cyc;
      end else if (run > 0) begin
        oe_runs.push_back(run);
        run = 0;
      end
      if (frame_done) fd_times.push_back(cyc);
      prev_clk = mat_clk;
      prev_lat = mat_lat;
    end

    // Shifted pixel data and address at each rising mat_clk
    chk("rise_count", rise_vec.size(), 32);
    for (int i = 0; i < rise_vec.size() && i < 32; i++) begin
      int k, slot, p, w, r0b, r1b, g0b;
      k    = i % 4;
      slot = i / 4;
      p    = slot % 2;
      w    = (slot / 2) % 2;
      r0b  = (k >> p) & 1;
      r1b  = ((3 - k) >> p) & 1;
      g0b  = (p == 0) ? w : 0;
      chk($sformatf("rise_data[%0d]", i), rise_vec[i], (g0b << 2) | (r1b << 1) | r0b);
      chk($sformatf("rise_addr[%0d]", i), rise_addr[i], (w << 2) | ((k + 1) % 4));
    end

    // Latch / OE / frame timing
    chk("first_rise", first_rise, 3);
    chk("first_lat", first_lat, 10);
    chk("first_oe", first_oe, 11);
    chk("lat_count", lat_rows.size(), 8);
    for (int i = 0; i < lat_rows.size() && i < 8; i++) begin
      chk($sformatf("lat_row[%0d]", i), lat_rows[i], (i / 2) % 2);
      chk($sformatf("rises_per_plane[%0d]", i), rises_per[i], 4);
    end
    chk("oe_run_count", oe_runs.size(), 8);
    for (int i = 0; i < oe_runs.size() && i < 8; i++)
      chk($sformatf("oe_run[%0d]", i), oe_runs[i], (i % 2 == 1) ? 4 : 2);
    chk("lat_width", lat_width_bad, 0);
    chk("lat_oe_high", lat_oe_bad, 0);
    chk("lat_then_oe", lat_follow_bad, 0);
    chk("fd_count", fd_times.size(), 2);
    if (fd_times.size() >= 2) begin
      chk("fd_first", fd_times[0], 56);
      chk("fd_second", fd_times[1], 112);
    end

    // Enable dropped early in row 0: frame still completes, then idle
    enable     = 1'b0;
    found      = 0;
    busy_at_fd = -1;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(negedge clk);
      cyc++;
      if (frame_done) begin
        found      = 1;
        busy_at_fd = int'(busy);
      end
    end
    chk("drop_fd_seen", found, 1);
    chk("drop_fd_cycle", cyc, 168);
    chk("drop_busy", busy_at_fd, 0);
    viol     = 0;
    prev_clk = mat_clk;
    repeat (20) begin
      @(negedge clk);
      if (busy || mat_clk || !mat_oe || (mat_clk && !prev_clk)) viol++;
      prev_clk = mat_clk;
    end
    chk("drop_idle_quiet", viol, 0);

    // Async reset while OE is active
    enable = 1'b1;
    found  = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(negedge clk);
      if (!mat_oe) found = 1;
    end
    chk("oe_window_seen", found, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_oe", mat_oe, 1);
    chk("async_busy", busy, 0);
    chk("async_row", mat_row, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_busy", busy, 1);
    chk("restart_addr", fb_addr, 0);
    repeat (10) @(negedge clk);
    chk("restart_lat", mat_lat, 1);
    chk("restart_row", mat_row, 0);
    @(negedge clk);
    chk("restart_oe0", mat_oe, 0);
    @(negedge clk);
    chk("restart_oe1", mat_oe, 0);
    @(negedge clk);
    chk("restart_oe_end", mat_oe, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
